// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle RV32I datapath (R/I/LW/SW, halt, retire)
// Optional CTRL_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
module multicycle_ctrl #(
   parameter int MEM_LAT = 0,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   output logic             pc_write,
   output logic             ir_write,
   output logic             mem_write,
   output logic             mdr_write,
   output logic             reg_write,
   output logic [2:0]       imm_ctrl,
   output logic [3:0]       alu_ctrl,
   output logic             alu_in2_ctrl,
   output logic             addrsrc_ctrl,
   output logic             regwrite_ctrl,
   output logic             retire,
   output logic             illegal,
   output logic             halted
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
`endif
);
   typedef enum logic [3:0] {FETCH, DECODE, EXEC_R, EXEC_I, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, HALT} state_t;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011, OP_SYS = 7'b1110011;
   state_t state, next;
   logic [3:0] wait_cnt, alu_map;
   logic illegal_q, illegal_set, last, counting, is_sw;
   assign last     = wait_cnt == 4'(MEM_LAT);
   assign counting = state == FETCH || state == MEMRD || state == MEMWR;
   assign is_sw    = opcode == OP_SW;
   always_comb begin
      case (funct3)
         3'b000: alu_map = (opcode == OP_R && funct7b5) ? 4'b0001 : 4'b0000;
         3'b001: alu_map = 4'b0101;
         3'b010: alu_map = 4'b1000;
         3'b011: alu_map = 4'b1001;
         3'b100: alu_map = 4'b0100;
         3'b101: alu_map = funct7b5 ? 4'b0111 : 4'b0110;
         3'b110: alu_map = 4'b0011;
         3'b111: alu_map = 4'b0010;
      endcase
   end
   always_comb begin
      next = state;
      illegal_set = 1'b0;
      pc_write = 1'b0;
      ir_write = 1'b0;
      mem_write = 1'b0;
      mdr_write = 1'b0;
      reg_write = 1'b0;
      imm_ctrl = 3'b000;
      alu_ctrl = 4'b0000;
      alu_in2_ctrl = 1'b0;
      addrsrc_ctrl = 1'b0;
      regwrite_ctrl = 1'b0;
      retire = 1'b0;
      illegal = illegal_q;
      halted = 1'b0;
      case (state)
         FETCH: if (last) begin
            pc_write = 1'b1;
            ir_write = 1'b1;
            next = DECODE;
         end
         DECODE: begin
            imm_ctrl = is_sw ? 3'b001 : 3'b000;
            next = opcode == OP_R ? EXEC_R : opcode == OP_I ? EXEC_I :
                   (opcode == OP_LW || is_sw) ? MEMADR : HALT;
            illegal_set = next == HALT && opcode != OP_SYS;
         end
         EXEC_R: begin
            alu_ctrl = alu_map;
            next = ALUWB;
         end
         EXEC_I: begin
            alu_ctrl = alu_map;
            alu_in2_ctrl = 1'b1;
            next = ALUWB;
         end
         // IR is unchanged, so the opcode still tells which EXEC state preceded
         ALUWB: begin
            alu_ctrl = alu_map;
            alu_in2_ctrl = opcode == OP_I;
            reg_write = 1'b1;
            retire = 1'b1;
            next = FETCH;
         end
         MEMADR: begin
            alu_in2_ctrl = 1'b1;
            imm_ctrl = is_sw ? 3'b001 : 3'b000;
            next = is_sw ? MEMWR : MEMRD;
         end
         MEMRD: begin
            alu_in2_ctrl = 1'b1;
            addrsrc_ctrl = 1'b1;
            mdr_write = last;
            next = last ? MEMWB : MEMRD;
         end
         MEMWB: begin
            reg_write = 1'b1;
            regwrite_ctrl = 1'b1;
            retire = 1'b1;
            next = FETCH;
         end
         MEMWR: begin
            alu_in2_ctrl = 1'b1;
            addrsrc_ctrl = 1'b1;
            imm_ctrl = 3'b001;
            mem_write = last;
            retire = last;
            next = last ? FETCH : MEMWR;
         end
         HALT: halted = 1'b1;
         default: next = FETCH;
      endcase
      if (!rst) begin
         pc_write = 1'b0;
         ir_write = 1'b0;
         mem_write = 1'b0;
         mdr_write = 1'b0;
         reg_write = 1'b0;
         imm_ctrl = 3'b000;
         alu_ctrl = 4'b0000;
         alu_in2_ctrl = 1'b0;
         addrsrc_ctrl = 1'b0;
         regwrite_ctrl = 1'b0;
         retire = 1'b0;
         illegal = 1'b0;
         halted = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= FETCH;
         wait_cnt <= 4'd0;
         illegal_q <= 1'b0;
      end else begin
         state <= next;
         wait_cnt <= (counting && !last) ? wait_cnt + 4'd1 : 4'd0;
         if (illegal_set) illegal_q <= 1'b1;
      end
   end
`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt <= '0;
         instret_cnt <= '0;
      end else if (state != HALT) begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (retire) instret_cnt <= instret_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven check of multicycle_ctrl at MEM_LAT 0, 2 and 3
module tb_multicycle_ctrl;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011, OP_SYS = 7'b1110011;
   // packed output order: pc,ir,memw,mdr,regw | imm[3] | alu[4] | in2,addr,rwc,ret,ill,hlt
   localparam logic [17:0] Z = 18'd0, FL = {5'b11000, 13'd0};
   logic clk = 1'b0, rst = 1'b0, f7 = 1'b0;
   logic [6:0] op = 7'd0;
   logic [2:0] f3 = 3'd0;
   int n_chk = 0, n_fail = 0;
   wire [17:0] o [3];
`ifdef CTRL_PERF_CNT_EN
   wire [31:0] cyc [3];
   wire [31:0] ins [3];
`endif
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : gi
      multicycle_ctrl #(.MEM_LAT(g == 0 ? 0 : g + 1), .CNT_W(32)) u (
         .clk(clk), .rst(rst), .opcode(op), .funct3(f3), .funct7b5(f7),
         .pc_write(o[g][17]), .ir_write(o[g][16]), .mem_write(o[g][15]),
         .mdr_write(o[g][14]), .reg_write(o[g][13]), .imm_ctrl(o[g][12:10]),
         .alu_ctrl(o[g][9:6]), .alu_in2_ctrl(o[g][5]), .addrsrc_ctrl(o[g][4]),
         .regwrite_ctrl(o[g][3]), .retire(o[g][2]), .illegal(o[g][1]), .halted(o[g][0])
`ifdef CTRL_PERF_CNT_EN
         , .cycle_cnt(cyc[g]), .instret_cnt(ins[g])
`endif
      );
   end
   typedef struct {
      int sel;
      logic [6:0] op;
      logic [2:0] f3;
      logic f7;
      int n;
      logic [17:0] e [10];
   } vec_t;
   vec_t tv [12];
   function automatic logic [17:0] ex(input logic i, input logic [3:0] a);
      return {8'd0, a, i, 5'b00000};
   endfunction
   function automatic logic [17:0] wb(input logic i, input logic [3:0] a);
      return {5'b00001, 3'b000, a, i, 5'b00100};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask
   task automatic start(input int sel, input logic [6:0] o_, input logic [2:0] f3_, input logic f7_);
      @(negedge clk);
      rst = 1'b0;
      op = o_;
      f3 = f3_;
      f7 = f7_;
      @(negedge clk);
      rst = 1'b1;
   endtask
   logic [17:0] LWE [10], SW0 [10], SW2 [10], SYS [10];
   initial begin
      LWE = '{Z, Z, FL, Z, ex(1, 0), 18'h30, 18'h30, {5'b00010, 13'h30}, {5'b00001, 13'h0C}, Z};
      SW0 = '{FL, 18'h400, 18'h420, {5'b00100, 13'h434}, FL, Z, Z, Z, Z, Z};
      SW2 = '{Z, Z, FL, 18'h400, 18'h420, 18'h430, 18'h430, {5'b00100, 13'h434}, Z, Z};
      SYS = '{FL, Z, 18'h1, 18'h1, Z, Z, Z, Z, Z, Z};
      tv[0]  = '{0, OP_I, 3'b000, 1'b0, 5, '{FL, Z, ex(1, 0), wb(1, 0), FL, Z, Z, Z, Z, Z}};
      tv[1]  = '{0, OP_I, 3'b000, 1'b1, 5, '{FL, Z, ex(1, 0), wb(1, 0), FL, Z, Z, Z, Z, Z}};
      tv[2]  = '{0, OP_I, 3'b101, 1'b1, 5, '{FL, Z, ex(1, 7), wb(1, 7), FL, Z, Z, Z, Z, Z}};
      tv[3]  = '{0, OP_I, 3'b101, 1'b0, 4, '{FL, Z, ex(1, 6), wb(1, 6), Z, Z, Z, Z, Z, Z}};
      tv[4]  = '{0, OP_R, 3'b000, 1'b1, 5, '{FL, Z, ex(0, 1), wb(0, 1), FL, Z, Z, Z, Z, Z}};
      tv[5]  = '{0, OP_R, 3'b111, 1'b0, 4, '{FL, Z, ex(0, 2), wb(0, 2), Z, Z, Z, Z, Z, Z}};
      tv[6]  = '{0, OP_R, 3'b011, 1'b0, 4, '{FL, Z, ex(0, 9), wb(0, 9), Z, Z, Z, Z, Z, Z}};
      tv[7]  = '{0, OP_I, 3'b001, 1'b1, 4, '{FL, Z, ex(1, 5), wb(1, 5), Z, Z, Z, Z, Z, Z}};
      tv[8]  = '{1, OP_LW, 3'b010, 1'b0, 10, LWE};
      tv[9]  = '{0, OP_SW, 3'b010, 1'b0, 5, SW0};
      tv[10] = '{1, OP_SW, 3'b010, 1'b0, 9, SW2};
      tv[11] = '{0, OP_SYS, 3'b000, 1'b0, 4, SYS};
      repeat (2) @(negedge clk);
      #1;
      for (int g = 0; g < 3; g++) chk($sformatf("reset u%0d", g), 32'(o[g]), 32'(Z));
      for (int k = 0; k < 12; k++) begin
         start(tv[k].sel, tv[k].op, tv[k].f3, tv[k].f7);
         for (int c = 0; c < tv[k].n; c++) begin
            #1 chk($sformatf("vec%0d cyc%0d", k, c + 1), 32'(o[tv[k].sel]), 32'(tv[k].e[c]));
            @(negedge clk);
         end
      end
      start(0, 7'b1111111, 3'b000, 1'b0);
      #1 chk("illegal fetch", 32'(o[0]), 32'(FL));
      @(negedge clk);
      for (int c = 0; c < 21; c++) begin
         @(negedge clk);
         #1 chk($sformatf("illegal halt %0d", c), 32'(o[0]), 32'h3);
      end
      rst = 1'b0;
      #1 chk("halt in reset", 32'(o[0]), 32'(Z));
      @(negedge clk);
      rst = 1'b1;
      op = OP_I;
      #1 chk("after halt reset", 32'(o[0]), 32'(FL));
      start(2, OP_LW, 3'b010, 1'b0);
      repeat (6) @(negedge clk);
      #1 chk("lat3 memrd", 32'(o[2]), 32'h30);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("lat3 rst low", 32'(o[2]), 32'(Z));
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1 chk($sformatf("lat3 refetch %0d", c + 1), 32'(o[2]), 32'(c == 3 ? FL : Z));
         @(negedge clk);
      end
`ifdef CTRL_PERF_CNT_EN
      start(0, OP_I, 3'b000, 1'b0);
      repeat (12) @(negedge clk);
      #1 chk("cycle_cnt", cyc[0], 32'd12);
      chk("instret_cnt", ins[0], 32'd3);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
